// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Program-counter sequencer for the IF stage. Drives the word address of a
// combinational instruction memory, captures the returned word into the IF/ID
// output register and advances the PC. Handles downstream backpressure,
// redirects from later stages, a start gate, and a halt on either a HALT_INSN
// word or a fetch past the end of memory.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds saturating 32-bit fetch_count / stall_count outputs.
//
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   start            - level; moves the block out of IDLE
//   imem_addr        - word index to instruction memory, {2'b00, pc[31:2]}
//   imem_data        - instruction word, combinational from imem_addr
//   redirect_valid   - one-cycle request to load redirect_pc
//   redirect_pc      - target byte address (bits [1:0] forced to 0)
//   ifid_valid       - output register holds a valid instruction
//   ifid_ready       - downstream accepts the output this cycle
//   ifid_instr       - fetched instruction
//   ifid_pc          - byte address of ifid_instr
//   ifid_npc         - ifid_pc + 4
//   halted           - high in HALT state
//   fault            - sticky out-of-range fetch flag
//   fetch_count      - (FETCH_PERF_CNT_EN) number of captures
//   stall_count      - (FETCH_PERF_CNT_EN) FETCH cycles with valid & !ready
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 128,
  parameter logic [31:0] HALT_INSN = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  input  logic        ifid_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic        halted,
  output logic        fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state;
  logic [31:0] pc;

  logic        free;
  logic        out_of_range;
  logic        in_fetch;
  logic        capture;
  logic [31:0] redirect_target;

  assign imem_addr       = {2'b00, pc[31:2]};
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // The output slot can take a new word if it is empty or being drained now.
  assign free         = !ifid_valid || ifid_ready;
  assign out_of_range = (pc[31:2] >= DEPTH_W);
  assign in_fetch     = (state == S_FETCH);
  // Redirect and the range check both outrank a capture.
  assign capture      = in_fetch && !redirect_valid && !out_of_range && free;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc    <= 32'h0;
      ifid_npc   <= 32'h0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ifid_valid <= 1'b0;
          if (redirect_valid) begin
            pc <= redirect_target;
          end else if (start) begin
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (redirect_valid) begin
            // Any un-accepted instruction is from the wrong path: drop it.
            pc         <= redirect_target;
            ifid_valid <= 1'b0;
          end else if (out_of_range && free) begin
            ifid_valid <= 1'b0;
            fault      <= 1'b1;
            halted     <= 1'b1;
            state      <= S_HALT;
          end else if (capture) begin
            ifid_instr <= imem_data;
            ifid_pc    <= pc;
            ifid_npc   <= pc + 32'd4;
            ifid_valid <= 1'b1;
            pc         <= pc + 32'd4;
            if (imem_data == HALT_INSN) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
          end
          // Otherwise stalled: everything holds.
        end

        S_HALT: begin
          if (redirect_valid) begin
            pc         <= redirect_target;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
            state      <= S_FETCH;
          end else if (ifid_ready) begin
            ifid_valid <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (capture && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (in_fetch && ifid_valid && !ifid_ready && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed testbench for fetch_sequencer. A 128-word behavioural instruction
// memory answers imem_addr combinationally. Inputs change 1 time unit after
// the rising edge; outputs are checked at that same point, well away from the
// next edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] HALT_INSN = 32'h0000_000C;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic        ifid_ready;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_npc;
  logic        halted;
  logic        fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (128),
    .HALT_INSN(HALT_INSN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ifid_valid    (ifid_valid),
    .ifid_ready    (ifid_ready),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_npc      (ifid_npc),
    .halted        (halted),
    .fault         (fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:0]] : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full IF/ID output bundle in one go.
  task automatic check_out(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] pc);
    check({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    check({tag, ".instr"}, ifid_instr, instr);
    check({tag, ".pc"},    ifid_pc,    pc);
    check({tag, ".npc"},   ifid_npc,   pc + 32'd4);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0]   = 32'h0023_00AA;
    mem[1]   = 32'h1065_4321;
    mem[2]   = 32'h0010_0022;
    mem[3]   = 32'h8C12_3456;
    mem[4]   = 32'h1111_1111;
    mem[5]   = HALT_INSN;
    mem[6]   = 32'h6666_6666;
    mem[127] = 32'hDEAD_BEEF;

    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ifid_ready     = 1'b0;

    // ---- reset state ----
    #12;
    check("rst.valid",  32'(ifid_valid), 32'h0);
    check("rst.instr",  ifid_instr, 32'h0);
    check("rst.pc",     ifid_pc,    32'h0);
    check("rst.npc",    ifid_npc,   32'h0);
    check("rst.halted", 32'(halted), 32'h0);
    check("rst.fault",  32'(fault),  32'h0);
    check("rst.addr",   imem_addr,  32'h0);
    tick();
    rst_n = 1'b1;

    // ---- sequential fetch ----
    start      = 1'b1;
    ifid_ready = 1'b1;
    tick();                                   // IDLE -> FETCH
    start = 1'b0;                             // dropping start must not return to IDLE
    check("seq.enter.valid", 32'(ifid_valid), 32'h0);
    tick(); check_out("seq0", 1'b1, 32'h0023_00AA, 32'h0);
    tick(); check_out("seq1", 1'b1, 32'h1065_4321, 32'h4);
    tick(); check_out("seq2", 1'b1, 32'h0010_0022, 32'h8);

    // ---- backpressure: 3 stalled cycles on pc=8 ----
    ifid_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 1'b1, 32'h0010_0022, 32'h8);
      check("stall.addr", imem_addr, 32'd3);
    end
    ifid_ready = 1'b1;
    tick(); check_out("resume", 1'b1, 32'h8C12_3456, 32'hC);

    // ---- redirect while stalled ----
    ifid_ready = 1'b0;
    tick(); check_out("stall2", 1'b1, 32'h8C12_3456, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_001B;
    tick();
    redirect_valid = 1'b0;
    ifid_ready     = 1'b1;
    check("redir.valid", 32'(ifid_valid), 32'h0);
    check("redir.addr",  imem_addr, 32'd6);
    tick(); check_out("redir.tgt", 1'b1, 32'h6666_6666, 32'h18);

    // ---- redirect together with ifid_ready: redirect wins ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    tick();
    redirect_valid = 1'b0;
    check("redir_rdy.valid", 32'(ifid_valid), 32'h0);
    check("redir_rdy.addr",  imem_addr, 32'd4);
    tick(); check_out("w4", 1'b1, 32'h1111_1111, 32'h10);

    // ---- halt instruction at pc=20 ----
    tick();
    check_out("halt.word", 1'b1, HALT_INSN, 32'h14);
    check("halt.halted", 32'(halted), 32'h1);
    ifid_ready = 1'b0;
    tick();
    check_out("halt.hold", 1'b1, HALT_INSN, 32'h14);
    check("halt.addr", imem_addr, 32'd6);
    ifid_ready = 1'b1;
    tick();
    check("halt.drain.valid", 32'(ifid_valid), 32'h0);
    tick();
    check("halt.idle.valid",  32'(ifid_valid), 32'h0);
    check("halt.idle.pc",     ifid_pc, 32'h14);
    check("halt.idle.halted", 32'(halted), 32'h1);

    // ---- redirect to 0 resumes ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("unhalt.halted", 32'(halted), 32'h0);
    check("unhalt.valid",  32'(ifid_valid), 32'h0);
    tick(); check_out("unhalt.w0", 1'b1, 32'h0023_00AA, 32'h0);

    // ---- out of range past word 127 ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_01FC;
    tick();
    redirect_valid = 1'b0;
    check("oor.redir.valid", 32'(ifid_valid), 32'h0);
    tick(); check_out("oor.w127", 1'b1, 32'hDEAD_BEEF, 32'h1FC);
    check("oor.w127.fault", 32'(fault), 32'h0);
    tick();
    check("oor.valid",  32'(ifid_valid), 32'h0);
    check("oor.fault",  32'(fault),  32'h1);
    check("oor.halted", 32'(halted), 32'h1);
    check("oor.addr",   imem_addr, 32'h80);

    // ---- fault is sticky across a resume ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("sticky.halted", 32'(halted), 32'h0);
    check("sticky.fault",  32'(fault),  32'h1);
    tick(); check_out("sticky.w0", 1'b1, 32'h0023_00AA, 32'h0);
    tick(); check_out("sticky.w1", 1'b1, 32'h1065_4321, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    // 11 captures; stalls: 3 on pc=8, then 2 on pc=12 (incl. the redirect cycle).
    check("perf.fetch", fetch_count, 32'd11);
    check("perf.stall", stall_count, 32'd5);
`endif

    // ---- async reset between edges ----
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid",  32'(ifid_valid), 32'h0);
    check("arst.instr",  ifid_instr, 32'h0);
    check("arst.pc",     ifid_pc,    32'h0);
    check("arst.npc",    ifid_npc,   32'h0);
    check("arst.fault",  32'(fault),  32'h0);
    check("arst.halted", 32'(halted), 32'h0);
    check("arst.addr",   imem_addr,  32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("arst.fetch", fetch_count, 32'h0);
    check("arst.stall", stall_count, 32'h0);
`endif
    #3;
    rst_n = 1'b1;

    // Stays in IDLE without start.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle.valid", 32'(ifid_valid), 32'h0);
    end
    start = 1'b1;
    tick();
    check("restart.enter.valid", 32'(ifid_valid), 32'h0);
    tick(); check_out("restart.w0", 1'b1, 32'h0023_00AA, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer for the IF stage. It drives the word address of the combinational 128-word instruction memory, captures the returned word into the IF/ID output register, and advances the PC.
- Handles downstream backpressure, branch/jump redirects from later stages, a start gate, and a halt on fetching past the end of memory.
- Sits between the instruction memory and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC at reset.
- DEPTH, 128, instruction memory depth in words; word index >= DEPTH is out of range.
- HALT_INSN, 32'h0000_000C, instruction word that halts fetch after it is delivered.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; leaves IDLE when high.
- imem_addr  output  32  word index to instruction memory, {2'b00, pc[31:2]}.
- imem_data  input  32  instruction word, combinational from imem_addr.
- redirect_valid  input  1  one-cycle request to load a new PC.
- redirect_pc  input  32  target byte address; bits [1:0] are ignored and forced to 0.
- ifid_valid  output  1  output register holds a valid instruction.
- ifid_ready  input  1  downstream accepts the output this cycle.
- ifid_instr  output  32  fetched instruction.
- ifid_pc  output  32  byte address of ifid_instr.
- ifid_npc  output  32  ifid_pc + 4.
- halted  output  1  high in HALT state.
- fault  output  1  sticky; set on an out-of-range fetch.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, pc = RESET_PC.
  - ifid_valid = 0; ifid_instr, ifid_pc and ifid_npc = 0; halted = 0; fault = 0.
- imem_addr = {2'b00, pc[31:2]} continuously, in every state.
- Slot free: free = !ifid_valid | ifid_ready.
- IDLE:
  - ifid_valid = 0.
  - start = 1 -> FETCH at the next edge.
  - A redirect in IDLE loads the PC and stays in IDLE.
- FETCH, priority order evaluated each edge:
  1. Redirect: redirect_valid -> pc = {redirect_pc[31:2], 2'b00}; ifid_valid = 0, dropping any un-accepted instruction; no capture this cycle.
  2. Out of range: pc[31:2] >= DEPTH with free -> ifid_valid = 0; fault = 1; state = HALT.
  3. Capture: free -> ifid_instr = imem_data, ifid_pc = pc, ifid_npc = pc + 4, ifid_valid = 1, pc = pc + 4. If imem_data == HALT_INSN -> state = HALT after this capture; the HALT_INSN word is still presented.
  4. Stall: not free -> all registers hold. Output remains stable until accepted.
- HALT:
  - halted = 1. The last captured word stays valid until ifid_ready, then ifid_valid = 0.
  - No new fetches.
  - redirect_valid -> load the PC, halted = 0, state = FETCH (fault stays set).
- Throughput and latency:
  - One instruction per cycle with ifid_ready held high.
  - Two cycles from redirect to the first valid output at the target: redirect edge, then capture edge.
- PC arithmetic is 32-bit and wraps modulo 2^32. Wrap is irrelevant in practice because the out-of-range check fires first.
- start is ignored outside IDLE. Deasserting start never returns the block to IDLE.
- Reset mid-stall or mid-HALT clears everything immediately, independent of clk.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, two 32-bit outputs are added:
  - fetch_count: increments on each capture.
  - stall_count: increments on each FETCH cycle with ifid_valid & !ifid_ready.
- Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When not defined, these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Sequential fetch: imem words 0..3 = 32'h002300AA, 32'h10654321, 32'h00100022, 32'h8C123456; start = 1, ifid_ready = 1.
  - Required: ifid_instr follows that sequence on consecutive cycles.
  - Required: ifid_pc = 0, 4, 8, 12 and ifid_npc = ifid_pc + 4.
- Backpressure: ifid_ready = 0 for 3 cycles while instr at pc = 8 is valid.
  - Required: ifid_instr = 32'h00100022 and pc = 12 held stable.
  - Required: after ready returns, the next capture is pc = 12; no duplicate and no skip.
- Redirect: redirect_valid with redirect_pc = 32'h0000_001B while stalled.
  - Required: ifid_valid = 0 the next cycle.
  - Required: the following cycle has ifid_pc = 32'h18, word index 6.
  - Redirect asserted in the same cycle as ifid_ready is also covered: redirect wins.
- Halt instruction: imem word 5 = HALT_INSN.
  - Required: the word at pc = 20 is delivered and halted = 1; no word at pc = 24 is fetched.
  - Required: a redirect to 0 resumes fetch and clears halted.
- Out of range: redirect to 32'h0000_01FC (word 127), then let the PC advance.
  - Required: word 127 is delivered; at pc = 32'h200, fault = 1, halted = 1 and ifid_valid = 0.
- Async reset: assert rst_n = 0 mid-stream between clock edges.
  - Required: all outputs clear immediately; after release, IDLE until start and the first fetch is at RESET_PC.
  - With FETCH_PERF_CNT_EN: counts match the captures and stall cycles of the preceding runs.
